// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 4-bit panel controller.
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT,
        IDLE,
        NIB_SETUP,
        NIB_EHI,
        NIB_HOLD,
        EXEC_WAIT
    } lcd_state_e;

    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_HOME       = 8'h02;
    localparam logic [7:0] LCD_FUNC_4B_2L = 8'h28;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_ENTRY_INC  = 8'h06;

    localparam int INIT_STEPS = 8;

    typedef struct packed {
        logic       is_nibble;
        logic [7:0] value;
        logic       long_wait;
        logic       init_nib_wait;
    } init_entry_t;

    // Power-on table: three 0x3 wake-ups and a 0x2 switch to 4-bit, then full bytes.
    function automatic init_entry_t init_entry(input logic [2:0] idx);
        init_entry_t e;
        case (idx)
            3'd0:    e = '{1'b1, 8'h03,          1'b0, 1'b1};
            3'd1:    e = '{1'b1, 8'h03,          1'b1, 1'b0};
            3'd2:    e = '{1'b1, 8'h03,          1'b1, 1'b0};
            3'd3:    e = '{1'b1, 8'h02,          1'b0, 1'b0};
            3'd4:    e = '{1'b0, LCD_FUNC_4B_2L, 1'b0, 1'b0};
            3'd5:    e = '{1'b0, LCD_DISP_ON,    1'b0, 1'b0};
            3'd6:    e = '{1'b0, LCD_CLEAR,      1'b1, 1'b0};
            default: e = '{1'b0, LCD_ENTRY_INC,  1'b0, 1'b0};
        endcase
        return e;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 4-bit controller: autonomous power-on init, then byte writes split
// into two E strobes followed by the panel's execution wait.
module lcd_hd44780_ctrl
    import lcd_pkg::*;
#(
    parameter int PWR_ON_CYC   = 1350000,
    parameter int INIT_NIB_CYC = 121500,
    parameter int SETUP_CYC    = 2,
    parameter int E_HIGH_CYC   = 16,
    parameter int E_HOLD_CYC   = 16,
    parameter int SHORT_CYC    = 1080,
    parameter int LONG_CYC     = 44000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] lcd_data,
    input  logic       lcd_write,
    input  logic       lcd_cmd_data,
    output logic       lcd_busy,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [3:0] lcd_db
);

    localparam int MAXC = max2(max2(max2(PWR_ON_CYC, INIT_NIB_CYC), max2(SETUP_CYC, E_HIGH_CYC)),
                               max2(max2(E_HOLD_CYC, SHORT_CYC), LONG_CYC));
    localparam int CW = $clog2(MAXC) + 1;
    typedef logic [CW-1:0] cnt_t;

    // Counter is loaded with N-1 so a phase of N cycles ends when it reads zero.
    localparam cnt_t PWR_LD   = cnt_t'(PWR_ON_CYC - 1);
    localparam cnt_t INIT_LD  = cnt_t'(INIT_NIB_CYC - 1);
    localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EHI_LD   = cnt_t'(E_HIGH_CYC - 1);
    localparam cnt_t EHOLD_LD = cnt_t'(E_HOLD_CYC - 1);
    localparam cnt_t SHORT_LD = cnt_t'(SHORT_CYC - 1);
    localparam cnt_t LONG_LD  = cnt_t'(LONG_CYC - 1);

    lcd_state_e  state_q;
    cnt_t        cnt_q;
    logic [2:0]  step_q;
    logic [7:0]  byte_q;
    logic        init_q, hi_q, busy_q, done_q, rs_q, e_q;
    logic [3:0]  db_q;

    init_entry_t ent;
    cnt_t        exec_ld_d;

    always_comb begin
        ent       = init_entry(step_q);
        exec_ld_d = SHORT_LD;
        if (init_q) begin
            if (ent.init_nib_wait)  exec_ld_d = INIT_LD;
            else if (ent.long_wait) exec_ld_d = LONG_LD;
        end else if (!rs_q && (byte_q == LCD_CLEAR || byte_q == LCD_HOME || byte_q == 8'h03)) begin
            exec_ld_d = LONG_LD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PWR_WAIT;
            cnt_q   <= PWR_LD;
            step_q  <= '0;
            byte_q  <= '0;
            init_q  <= 1'b1;
            hi_q    <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            db_q    <= '0;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    if (cnt_q == '0) state_q <= INIT;
                    else             cnt_q   <= cnt_q - cnt_t'(1);
                end
                INIT: begin
                    byte_q  <= ent.value;
                    hi_q    <= !ent.is_nibble;
                    rs_q    <= 1'b0;
                    db_q    <= ent.is_nibble ? ent.value[3:0] : ent.value[7:4];
                    cnt_q   <= SETUP_LD;
                    state_q <= NIB_SETUP;
                end
                IDLE: begin
                    if (lcd_write) begin
                        byte_q  <= lcd_data;
                        rs_q    <= lcd_cmd_data;
                        db_q    <= lcd_data[7:4];
                        hi_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        cnt_q   <= SETUP_LD;
                        state_q <= NIB_SETUP;
                    end
                end
                NIB_SETUP: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b1;
                        cnt_q   <= EHI_LD;
                        state_q <= NIB_EHI;
                    end else cnt_q <= cnt_q - cnt_t'(1);
                end
                NIB_EHI: begin
                    if (cnt_q == '0) begin
                        e_q     <= 1'b0;
                        cnt_q   <= EHOLD_LD;
                        state_q <= NIB_HOLD;
                    end else cnt_q <= cnt_q - cnt_t'(1);
                end
                NIB_HOLD: begin
                    if (cnt_q == '0) begin
                        if (hi_q) begin
                            hi_q    <= 1'b0;
                            db_q    <= byte_q[3:0];
                            cnt_q   <= SETUP_LD;
                            state_q <= NIB_SETUP;
                        end else begin
                            cnt_q   <= exec_ld_d;
                            state_q <= EXEC_WAIT;
                        end
                    end else cnt_q <= cnt_q - cnt_t'(1);
                end
                EXEC_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end else if (init_q && step_q != 3'(INIT_STEPS - 1)) begin
                        step_q  <= step_q + 3'd1;
                        state_q <= INIT;
                    end else begin
                        init_q  <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end

    assign lcd_busy  = busy_q;
    assign init_done = done_q;
    assign lcd_rs    = rs_q;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = e_q;
    assign lcd_db    = db_q;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: expected (RS, DB) per E rising edge is queued at stimulus
// time and popped by a monitor; execution waits are timed from E edges.
module tb_lcd_hd44780_ctrl;

    localparam int SHORT = 10;
    localparam int LONG  = 50;
    localparam int EHI   = 2;
    localparam int EHOLD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] lcd_data = '0;
    logic       lcd_write = 1'b0;
    logic       lcd_cmd_data = 1'b0;
    logic       lcd_busy, init_done, lcd_rs, lcd_rw, lcd_e;
    logic [3:0] lcd_db;

    typedef struct packed {
        logic       rs;
        logic [3:0] db;
    } pulse_t;

    pulse_t exp_q[$];
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    lcd_hd44780_ctrl #(
        .PWR_ON_CYC(100), .INIT_NIB_CYC(40), .SETUP_CYC(1), .E_HIGH_CYC(EHI),
        .E_HOLD_CYC(EHOLD), .SHORT_CYC(SHORT), .LONG_CYC(LONG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lcd_data(lcd_data), .lcd_write(lcd_write),
        .lcd_cmd_data(lcd_cmd_data), .lcd_busy(lcd_busy), .init_done(init_done),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic prev_e = 1'b0;
    always @(negedge clk) begin
        pulse_t p;
        if (lcd_e && !prev_e) begin
            if (exp_q.size() == 0) begin
                chk("extra_e", 32'(1), 32'(0));
            end else begin
                p = exp_q.pop_front();
                chk("pulse_rs", 32'(lcd_rs), 32'(p.rs));
                chk("pulse_db", 32'(lcd_db), 32'(p.db));
                chk("pulse_rw", 32'(lcd_rw), 32'(0));
            end
        end
        prev_e <= lcd_e;
    end

    task automatic push_byte(input logic rs, input logic [7:0] d);
        exp_q.push_back(pulse_t'{rs, d[7:4]});
        exp_q.push_back(pulse_t'{rs, d[3:0]});
    endtask

    task automatic push_init();
        logic [3:0] nibs [12];
        nibs = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h6};
        foreach (nibs[i]) exp_q.push_back(pulse_t'{1'b0, nibs[i]});
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        while (lcd_busy && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(lcd_busy), 32'(0));
    endtask

    // Drive on the current (idle) negedge; inputs are scrambled after the accept cycle.
    task automatic do_write(input logic cd, input logic [7:0] d);
        push_byte(cd, d);
        lcd_data     = d;
        lcd_cmd_data = cd;
        lcd_write    = 1'b1;
        @(negedge clk);
        lcd_write    = 1'b0;
        lcd_data     = 8'($urandom);
        lcd_cmd_data = ~cd;
        chk("busy_next", 32'(lcd_busy), 32'(1));
    endtask

    // Cycles from the second E rise to busy falling = E high + E hold + exec wait.
    task automatic exec_time(input int expc, input string tag, input bit poke);
        int   rises, n;
        logic pe;
        bit   poked;
        rises = 0; n = 0; pe = lcd_e; poked = 0;
        while (rises < 2 && n < 500) begin
            @(negedge clk);
            n++;
            lcd_write = 1'b0;
            if (lcd_e && !pe) rises++;
            pe = lcd_e;
            if (poke && rises == 1 && !poked) begin
                lcd_write    = 1'b1;
                lcd_data     = 8'hFF;
                lcd_cmd_data = ~lcd_cmd_data;
                poked        = 1;
            end
        end
        lcd_write = 1'b0;
        chk({tag, "_rises"}, 32'(rises), 32'(2));
        n = 0;
        while (lcd_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n), 32'(expc));
    endtask

    initial begin
        int   qbad, n;
        logic [7:0] sd [3];
        logic       sc [3];

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(lcd_busy), 32'(1));
        chk("rst_done", 32'(init_done), 32'(0));
        chk("rst_e", 32'(lcd_e), 32'(0));
        chk("rst_db", 32'(lcd_db), 32'(0));
        chk("rst_rs", 32'(lcd_rs), 32'(0));
        chk("rst_rw", 32'(lcd_rw), 32'(0));

        push_init();
        rst_n = 1'b1;
        qbad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (lcd_e || !lcd_busy) qbad++;
            lcd_write = (i == 50);
        end
        lcd_write = 1'b0;
        chk("pwr_quiet", 32'(qbad), 32'(0));
        repeat (20) @(negedge clk);
        lcd_data = 8'h55; lcd_write = 1'b1;
        @(negedge clk);
        lcd_write = 1'b0;
        wait_idle(3000, "init_to");
        chk("init_done", 32'(init_done), 32'(1));
        chk("init_left", 32'(exp_q.size()), 32'(0));
        chk("idle_e", 32'(lcd_e), 32'(0));

        do_write(1'b1, 8'h41);
        exec_time(EHI + EHOLD + SHORT, "exec_41", 0);
        do_write(1'b0, 8'h01);
        exec_time(EHI + EHOLD + LONG, "exec_clr", 0);
        do_write(1'b0, 8'hC5);
        exec_time(EHI + EHOLD + SHORT, "exec_c5", 1);

        push_byte(1'b1, 8'h5A);
        lcd_data = 8'h5A; lcd_cmd_data = 1'b1; lcd_write = 1'b1;
        repeat (3) @(negedge clk);
        lcd_write = 1'b0;
        wait_idle(500, "held_to");
        repeat (5) @(negedge clk);
        chk("held_left", 32'(exp_q.size()), 32'(0));

        do_write(1'b1, 8'h33);
        n = 0;
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ehi_to", 32'(lcd_e), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_e", 32'(lcd_e), 32'(0));
        chk("mid_rst_busy", 32'(lcd_busy), 32'(1));
        chk("mid_rst_done", 32'(init_done), 32'(0));
        exp_q.delete();
        @(negedge clk);
        push_init();
        rst_n = 1'b1;
        @(negedge clk);
        wait_idle(3000, "reinit_to");
        chk("reinit_done", 32'(init_done), 32'(1));
        chk("reinit_left", 32'(exp_q.size()), 32'(0));

        sd = '{8'hC0, 8'h48, 8'h49};
        sc = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            wait_idle(500, "stream_to");
            do_write(sc[i], sd[i]);
        end
        wait_idle(500, "stream_end_to");
        repeat (5) @(negedge clk);
        chk("stream_left", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_hd44780_ctrl.md
Name: lcd_hd44780_ctrl

Overview:
- Low-level HD44780 character-LCD controller driving the physical panel pins in 4-bit mode; sits directly downstream of the text-display front end and consumes its byte-write interface (lcd_data / lcd_write / lcd_cmd_data / lcd_busy).
- After reset it runs the power-on init sequence autonomously.
- It then serialises each accepted command or data byte into two nibble strobes and holds busy for the panel's execution time.

Parameters:
- PWR_ON_CYC, 1350000, cycles waited after reset before the first nibble (50 ms at 27 MHz).
- INIT_NIB_CYC, 121500, wait after the first 0x3 init nibble (4.5 ms).
- SETUP_CYC, 2, RS/DB valid before E rises.
- E_HIGH_CYC, 16, E high width.
- E_HOLD_CYC, 16, E low after the falling edge, before the next nibble or wait.
- SHORT_CYC, 1080, execution wait for normal instructions and data (40 us).
- LONG_CYC, 44000, execution wait for clear/home (1.63 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- lcd_data  in  8  byte to send
- lcd_write  in  1  one-cycle write strobe
- lcd_cmd_data  in  1  0 = instruction (RS=0), 1 = data (RS=1)
- lcd_busy  out  1  high while initialising or transferring/executing; writes are ignored while high
- init_done  out  1  sticky high once the init sequence completes
- lcd_rs  out  1  panel RS
- lcd_rw  out  1  panel RW, constant 0 (write-only)
- lcd_e  out  1  panel enable strobe
- lcd_db  out  4  panel DB7..DB4

Interface decisions:
- One clock, clk; reset rst_n is asynchronous, active-low.
- All outputs are registered.

Behaviour:
- Reset values: lcd_busy=1, init_done=0, lcd_rs=0, lcd_rw=0, lcd_e=0, lcd_db=0.
- Reset asserted mid-operation returns to these values immediately and restarts power-on init; no partial byte completes.

States:
- PWR_WAIT: counts PWR_ON_CYC, then goes to INIT.
- INIT: steps through an 8-entry init table, one step per item.
  - nib 0x3, wait INIT_NIB_CYC
  - nib 0x3, wait LONG_CYC
  - nib 0x3, wait LONG_CYC
  - nib 0x2, wait SHORT_CYC
  - byte 0x28, wait SHORT
  - byte 0x0C, wait SHORT
  - byte 0x01, wait LONG
  - byte 0x06, wait SHORT
  - All init entries use RS=0.
- IDLE: lcd_busy=0.
  - lcd_write=1 is accepted here; the byte and RS are latched and the state goes to NIB_SETUP.
  - lcd_busy=1 from the next cycle.
- Nibble strobe, three sub-phases:
  - NIB_SETUP: lcd_rs and lcd_db driven, lcd_e=0, for SETUP_CYC cycles.
  - NIB_EHI: lcd_e=1 for E_HIGH_CYC cycles.
  - NIB_HOLD: lcd_e=0 for E_HOLD_CYC cycles; lcd_db and lcd_rs stay stable throughout.
- Bytes go high nibble (data[7:4]) then low nibble (data[3:0]); single-nibble init steps send one strobe only.
- EXEC_WAIT: after the last strobe's hold, wait SHORT_CYC or LONG_CYC, then go to IDLE (or the next init step).
  - LONG_CYC applies when RS=0 and byte ∈ {0x01, 0x02, 0x03}; all else uses SHORT_CYC.
- init_done rises in the same cycle IDLE is first entered; it stays high until reset.

Boundary conditions:
- lcd_write while lcd_busy=1 (including during init) is ignored and never queued.
- lcd_write held high across multiple IDLE cycles: only the first cycle is accepted; the block is busy afterwards.
- lcd_data and lcd_cmd_data are sampled only in the accept cycle; later changes do not affect the transfer.
- Outputs in IDLE: lcd_e=0; lcd_db and lcd_rs hold their last driven values.
- One shared down-counter serves every wait. Its width is $clog2 of the maximum parameter + 1; a phase of N cycles lasts exactly N cycles (N ≥ 1).

Decomposition:
- lcd_pkg holds:
  - the state enum;
  - instruction constants LCD_CLEAR=0x01, LCD_HOME=0x02, LCD_FUNC_4B_2L=0x28, LCD_DISP_ON=0x0C, LCD_ENTRY_INC=0x06;
  - the init-table entry struct {is_nibble, value[7:0], long_wait, init_nib_wait}.
- Optional sub-module lcd_delay_timer (load value, count down, done pulse), instanced once.

Test Plan (bench overrides: PWR_ON=100, INIT_NIB=40, SETUP=1, E_HIGH=2, E_HOLD=2, SHORT=10, LONG=50):
- Reset release -> lcd_e=0 and lcd_busy=1 for 100 cycles. Then exactly 12 E pulses with RS=0 and lcd_db at each rising E = 3,3,3,2,2,8,0,C,0,1,0,6. Then init_done=1 and lcd_busy=0.
- Idle, write data 0x41 (cmd_data=1) -> lcd_busy=1 next cycle. Two pulses with rs=1, db=4 then 1. lcd_busy falls exactly 10 cycles after the second hold ends.
- Write cmd 0x01 -> rs=0, db=0 then 1, 50-cycle execution wait. Cmd 0xC5 -> 10-cycle wait.
- lcd_write pulsed mid-transfer and during init -> no extra E pulses, no change to in-flight nibbles.
- Deassert rst_n during NIB_EHI of a data byte -> lcd_e=0, lcd_busy=1, init_done=0 within the same cycle. Full init sequence repeats after release.
- Front-end-style stream: cmd 0xC0, then data 0x48, 0x49, each issued on the first cycle busy=0 -> 6 pulses, nibbles C,0,4,8,4,9, correct RS per byte, nothing dropped.
